// File: rtl/ysyx_23060075_sram_if.sv
// ysyx_23060075_sram_if: request/response bus between the core data port and the SRAM responder
interface ysyx_23060075_sram_if;
  logic req_valid;
  logic req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0] req_mask;
  logic req_wen;
  logic req_ren;
  logic rsp_valid;
  logic rsp_ready;
  logic [31:0] rsp_rdata;
  logic rsp_err;
  modport master (
    output req_valid, req_addr, req_wdata, req_mask, req_wen, req_ren, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input req_valid, req_addr, req_wdata, req_mask, req_wen, req_ren, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ysyx_23060075_sram.sv
// ysyx_23060075_sram: handshaked fixed-latency data SRAM with masked writes and error responses; YSYX_23060075_SRAM_RAND_LAT_EN adds LFSR latency jitter
module ysyx_23060075_sram #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 1
) (
  input logic clk,
  input logic rst,
  ysyx_23060075_sram_if.slave bus
);
  localparam int IW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic [31:0] addr_q, wdata_q, rdata_q, off;
  logic [3:0] mask_q, emask;
  logic wen_q, ren_q, err_q, err, accept, commit;
  logic [4:0] cnt, cnt_ld;
  logic [IW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  assign off = addr_q - ADDR_BASE;
  assign idx = off[IW+1:2];
  assign emask = mask_q << addr_q[1:0];
  assign err = (wen_q == ren_q) || (addr_q < ADDR_BASE) || ((off >> 2) >= 32'(DEPTH_WORDS)) ||
               (mask_q == 4'b0011 && addr_q[0]) || (mask_q == 4'b1111 && addr_q[1:0] != 2'd0) ||
               (wen_q && mask_q != 4'b0001 && mask_q != 4'b0011 && mask_q != 4'b1111);
  assign accept = state == IDLE && bus.req_valid;
  assign commit = state == BUSY && cnt == 5'd1;
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err = err_q;
`ifdef YSYX_23060075_SRAM_RAND_LAT_EN
  logic [7:0] lfsr;
  // Step the latency LFSR once per accepted request
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= 8'hA5;
    else if (accept) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign cnt_ld = 5'(LATENCY) + {3'd0, lfsr[1:0]};
`else
  assign cnt_ld = 5'(LATENCY);
`endif
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Next state: accept in IDLE, count down in BUSY, wait for the requester in RESP
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (bus.req_valid ? BUSY : IDLE) :
              state == BUSY ? (cnt == 5'd1 ? RESP : BUSY) :
              (bus.rsp_ready ? IDLE : RESP);
  end
  // Latch the request, run the latency counter and register the response at commit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q <= '0;
      wdata_q <= '0;
      mask_q <= '0;
      wen_q <= 1'b0;
      ren_q <= 1'b0;
      cnt <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      addr_q <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      mask_q <= bus.req_mask;
      wen_q <= bus.req_wen;
      ren_q <= bus.req_ren;
      cnt <= cnt_ld;
    end else if (state == BUSY) begin
      cnt <= cnt - 5'd1;
      if (commit) begin
        rdata_q <= (err || wen_q) ? 32'd0 : mem[idx];
        err_q <= err;
      end
    end
  // Masked byte-lane write; the array itself is never reset
  always_ff @(posedge clk)
    if (commit && wen_q && !err)
      for (int b = 0; b < 4; b++)
        if (emask[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
endmodule
